// File: rtl/fetch_pkg.sv
// Shared types and widths for the byte-serial instruction fetch unit.
package fetch_pkg;
  localparam int ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int BYTE_W = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A0   = 3'd1,
    S_B0   = 3'd2,
    S_B1   = 3'd3,
    S_B2   = 3'd4,
    S_B3   = 3'd5,
    S_HOLD = 3'd6
  } fetch_state_e;
endpackage

// File: rtl/inst_fetch.sv
// Fetches a 32-bit little-endian instruction from a byte-wide RAM with one-cycle
// read latency, then holds it until decode accepts it.
module inst_fetch
  import fetch_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic              pc_valid_in,
  output logic              pc_ready_out,
  input  logic              flush_in,
  output logic [ADDR_W-1:0] mem_a_out,
  output logic              mem_wr_out,
  input  logic [BYTE_W-1:0] mem_din,
  output logic [INST_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc_out,
  output logic              inst_valid_out,
  input  logic              id_ready_in
);

  fetch_state_e             state_q, state_d;
  logic [ADDR_W-1:0]        pc_q, pc_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [2:0][BYTE_W-1:0]   buf_q, buf_d;
  logic [INST_W-1:0]        inst_q, inst_d;
  logic [ADDR_W-1:0]        ipc_q, ipc_d;

  assign pc_ready_out   = (state_q == S_IDLE) & rdy_in & ~flush_in;
  assign mem_a_out      = addr_q;
  assign mem_wr_out     = 1'b0;
  assign inst_out       = inst_q;
  assign inst_pc_out    = ipc_q;
  assign inst_valid_out = (state_q == S_HOLD);

  // The address runs one state ahead of the capture: data for the byte issued
  // in state X arrives while in the state after X.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    buf_d   = buf_q;
    inst_d  = inst_q;
    ipc_d   = ipc_q;
    if (rdy_in) begin
      if (flush_in) begin
        state_d = S_IDLE;
        buf_d   = '0;
      end else begin
        unique case (state_q)
          S_IDLE: if (pc_valid_in) begin
            state_d = S_A0;
            pc_d    = pc_in;
            addr_d  = pc_in;
          end
          S_A0: begin
            addr_d  = pc_q + 32'd1;
            state_d = S_B0;
          end
          S_B0: begin
            buf_d[0] = mem_din;
            addr_d   = pc_q + 32'd2;
            state_d  = S_B1;
          end
          S_B1: begin
            buf_d[1] = mem_din;
            addr_d   = pc_q + 32'd3;
            state_d  = S_B2;
          end
          S_B2: begin
            buf_d[2] = mem_din;
            state_d  = S_B3;
          end
          S_B3: begin
            inst_d  = {mem_din, buf_q[2], buf_q[1], buf_q[0]};
            ipc_d   = pc_q;
            state_d = S_HOLD;
          end
          S_HOLD: if (id_ready_in) state_d = S_IDLE;
          default: state_d = S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      addr_q  <= '0;
      buf_q   <= '0;
      inst_q  <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      buf_q   <= buf_d;
      inst_q  <= inst_d;
      ipc_q   <= ipc_d;
    end
  end

endmodule
